// File: rtl/dma_xfer_responder_if.sv
// Handshake bundle between a DMA initiator and the transfer responder.
// The initiator (master) drives go and dma_req; the responder (slave) drives the rest.
interface dma_xfer_responder_if;
  logic       go;
  logic       dma_req;
  logic       dma_gnt;
  logic       data_transfer;
  logic [7:0] beat_cnt;
  logic       xfer_done;
  logic       xfer_abort;

  modport master (
    output go,
    output dma_req,
    input  dma_gnt,
    input  data_transfer,
    input  beat_cnt,
    input  xfer_done,
    input  xfer_abort
  );

  modport slave (
    input  go,
    input  dma_req,
    output dma_gnt,
    output data_transfer,
    output beat_cnt,
    output xfer_done,
    output xfer_abort
  );
endinterface

// File: rtl/dma_xfer_responder.sv
// DMA transfer responder: accepts a request, grants it GNT_DLY cycles later, then
// signals BURST_LEN transfer beats followed by a one-cycle done pulse.
// Optional feature: define DMA_XFER_RESP_ABORT_EN to let a dropped dma_req during
// the burst abort it (xfer_abort pulse instead of xfer_done). Without it,
// xfer_abort is tied low and every accepted burst runs to completion.
// Every output comes straight from a flop; the flops are loaded from the next state.
module dma_xfer_responder #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned GNT_DLY   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  dma_xfer_responder_if.slave        bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StGrant,
    StXfer,
    StDone
  } state_e;

  localparam logic [7:0] BeatLast = 8'(BURST_LEN);
  // WAIT covers GNT_DLY-1 cycles; with GNT_DLY=1 there is nothing to count, so the
  // accepting edge goes straight to GRANT to keep the grant one cycle after acceptance.
  localparam bit         SkipWait = (GNT_DLY == 1);
  localparam logic [3:0] WaitLast = (GNT_DLY > 1) ? 4'(GNT_DLY - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic       data_transfer_q, data_transfer_d;
  logic       xfer_done_q, xfer_done_d;
`ifdef DMA_XFER_RESP_ABORT_EN
  logic       xfer_abort_q, xfer_abort_d;
`endif

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
`ifdef DMA_XFER_RESP_ABORT_EN
    xfer_abort_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (bus.go && bus.dma_req) begin
          beat_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = SkipWait ? StGrant : StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          state_d = StGrant;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StGrant: begin
        state_d    = StXfer;
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
      StXfer: begin
        if (beat_cnt_q == BeatLast) begin
          state_d = StDone;
`ifdef DMA_XFER_RESP_ABORT_EN
        end else if (!bus.dma_req) begin
          // Count stays frozen at the beats already delivered.
          state_d      = StIdle;
          xfer_abort_d = 1'b1;
`endif
        end else begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    dma_gnt_d       = (state_d == StGrant);
    data_transfer_d = (state_d == StXfer);
    xfer_done_d     = (state_d == StDone);
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      wait_cnt_q      <= '0;
      beat_cnt_q      <= '0;
      dma_gnt_q       <= 1'b0;
      data_transfer_q <= 1'b0;
      xfer_done_q     <= 1'b0;
`ifdef DMA_XFER_RESP_ABORT_EN
      xfer_abort_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      dma_gnt_q       <= dma_gnt_d;
      data_transfer_q <= data_transfer_d;
      xfer_done_q     <= xfer_done_d;
`ifdef DMA_XFER_RESP_ABORT_EN
      xfer_abort_q    <= xfer_abort_d;
`endif
    end
  end

  assign bus.dma_gnt       = dma_gnt_q;
  assign bus.data_transfer = data_transfer_q;
  assign bus.beat_cnt      = beat_cnt_q;
  assign bus.xfer_done     = xfer_done_q;
`ifdef DMA_XFER_RESP_ABORT_EN
  assign bus.xfer_abort    = xfer_abort_q;
`else
  assign bus.xfer_abort    = 1'b0;
`endif

endmodule
